// File: rtl/hilo_pkg.sv
// rtl/hilo_pkg.sv - op codes, FSM states and op predicates for the HI/LO MAC unit
package hilo_pkg;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_WHI   = 3'd1;
    localparam logic [2:0] OP_WLO   = 3'd2;
    localparam logic [2:0] OP_WBOTH = 3'd3;
    localparam logic [2:0] OP_MADD  = 3'd4;
    localparam logic [2:0] OP_MADDU = 3'd5;
    localparam logic [2:0] OP_MSUB  = 3'd6;
    localparam logic [2:0] OP_MSUBU = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        ACC  = 2'd2
    } hilo_state_t;

    // Accumulate ops occupy the upper half of the op space
    function automatic logic is_acc(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic is_signed(input logic [2:0] op);
        return (op == OP_MADD) || (op == OP_MSUB);
    endfunction

    function automatic logic is_sub(input logic [2:0] op);
        return (op == OP_MSUB) || (op == OP_MSUBU);
    endfunction

endpackage

// File: rtl/hilo_mac_dp.sv
// rtl/hilo_mac_dp.sv - operand latch, product register and 2*DW add/subtract
module hilo_mac_dp
    import hilo_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            latch_en_i,
    input  logic            mul_en_i,
    input  logic [2:0]      op_i,
    input  logic [DW-1:0]   a_i,
    input  logic [DW-1:0]   b_i,
    input  logic [2*DW-1:0] base_i,
    output logic [2*DW-1:0] result_o
);

    logic [DW-1:0]   a_q;
    logic [DW-1:0]   b_q;
    logic [2:0]      op_q;
    logic [2*DW-1:0] prod_q;
    logic [2*DW-1:0] ext_a;
    logic [2*DW-1:0] ext_b;
    logic [2*DW-1:0] prod_d;

    // Extend operands to full width so one modulo-2^(2*DW) multiply serves both signednesses
    always_comb begin
        ext_a  = {{DW{1'b0}}, a_q};
        ext_b  = {{DW{1'b0}}, b_q};
        if (is_signed(op_q)) begin
            ext_a = {{DW{a_q[DW-1]}}, a_q};
            ext_b = {{DW{b_q[DW-1]}}, b_q};
        end
        prod_d = ext_a * ext_b;
    end

    // Latch operands on accept, register the product during MUL; reset discards both
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= OP_NOP;
            prod_q <= '0;
        end else begin
            if (latch_en_i) begin
                a_q  <= a_i;
                b_q  <= b_i;
                op_q <= op_i;
            end
            if (mul_en_i) begin
                prod_q <= prod_d;
            end
        end
    end

    // Wrapping accumulate/subtract against the current {HI,LO}
    always_comb begin
        result_o = is_sub(op_q) ? (base_i - prod_q) : (base_i + prod_q);
    end

endmodule

// File: rtl/hilo_mac.sv
// rtl/hilo_mac.sv - HI/LO register pair with direct writes and multi-cycle multiply-accumulate
module hilo_mac
    import hilo_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [2:0]    req_op,
    input  logic [DW-1:0] hi_in,
    input  logic [DW-1:0] lo_in,
    input  logic [DW-1:0] src_a,
    input  logic [DW-1:0] src_b,
    output logic [DW-1:0] hi_o,
    output logic [DW-1:0] lo_o,
    output logic          busy,
    output logic          done
);

    hilo_state_t     state_q;
    logic [DW-1:0]   hi_q;
    logic [DW-1:0]   lo_q;
    logic            done_q;
    logic            accept;
    logic [2*DW-1:0] acc_result;

    // Handshake: only IDLE accepts, and never while reset is asserted
    always_comb begin
        req_ready = (state_q == IDLE) && !rst;
        accept    = req_valid && req_ready;
    end

    hilo_mac_dp #(.DW(DW)) u_dp (
        .clk        (clk),
        .rst        (rst),
        .latch_en_i (accept && is_acc(req_op)),
        .mul_en_i   (state_q == MUL),
        .op_i       (req_op),
        .a_i        (src_a),
        .b_i        (src_b),
        .base_i     ({hi_q, lo_q}),
        .result_o   (acc_result)
    );

    // FSM plus HI/LO registers: writes in IDLE, accumulate result lands at the ACC edge
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        case (req_op)
                            OP_WHI:   hi_q <= hi_in;
                            OP_WLO:   lo_q <= lo_in;
                            OP_WBOTH: begin
                                hi_q <= hi_in;
                                lo_q <= lo_in;
                            end
                            default: begin
                                if (is_acc(req_op)) begin
                                    state_q <= MUL;
                                end
                            end
                        endcase
                    end
                end
                MUL: state_q <= ACC;
                ACC: begin
                    {hi_q, lo_q} <= acc_result;
                    done_q       <= 1'b1;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Outputs come straight from registers
    always_comb begin
        hi_o = hi_q;
        lo_o = lo_q;
        busy = (state_q != IDLE);
        done = done_q;
    end

endmodule

// File: tb/tb_hilo_mac.sv
// tb/tb_hilo_mac.sv - randomized and directed self-checking bench for hilo_mac
module tb_hilo_mac;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] hi_in;
    logic [31:0] lo_in;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        busy;
    logic        done;

    int vectors;
    int miscompares;
    bit check_en;

    hilo_mac #(.DW(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .hi_in     (hi_in),
        .lo_in     (lo_in),
        .src_a     (src_a),
        .src_b     (src_b),
        .hi_o      (hi_o),
        .lo_o      (lo_o),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: cycles left before an accumulate result lands (0 = idle)
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    int          m_left;
    logic        m_done;
    logic [31:0] m_a;
    logic [31:0] m_b;
    logic [2:0]  m_op;

    function automatic logic [63:0] model_mac(input logic [63:0] base, input logic [2:0] op,
                                              input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        logic [63:0] p;
        if (op == 3'd4 || op == 3'd6) begin
            sa = $signed(a);
            sb = $signed(b);
            p  = sa * sb;
        end else begin
            p = {32'h0, a} * {32'h0, b};
        end
        return (op >= 3'd6) ? base - p : base + p;
    endfunction

    initial begin
        m_hi = 0; m_lo = 0; m_left = 0; m_done = 0; m_a = 0; m_b = 0; m_op = 0;
    end

    always @(posedge clk) begin
        if (rst) begin
            m_hi = 0; m_lo = 0; m_left = 0; m_done = 0;
        end else if (m_left == 0) begin
            m_done = 0;
            if (req_valid) begin
                case (req_op)
                    3'd1: m_hi = hi_in;
                    3'd2: m_lo = lo_in;
                    3'd3: begin m_hi = hi_in; m_lo = lo_in; end
                    3'd4, 3'd5, 3'd6, 3'd7: begin
                        m_a = src_a; m_b = src_b; m_op = req_op; m_left = 2;
                    end
                    default: ;
                endcase
            end
        end else begin
            m_left = m_left - 1;
            m_done = 0;
            if (m_left == 0) begin
                {m_hi, m_lo} = model_mac({m_hi, m_lo}, m_op, m_a, m_b);
                m_done = 1;
            end
        end
    end

    // Cycle-by-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (check_en) begin
            vectors = vectors + 1;
            if (hi_o !== m_hi || lo_o !== m_lo || busy !== (m_left != 0) || done !== m_done ||
                req_ready !== ((m_left == 0) && !rst)) begin
                miscompares = miscompares + 1;
                $display("FAIL model t=%0t got hi=%h lo=%h busy=%b done=%b rdy=%b want hi=%h lo=%h busy=%b done=%b rdy=%b",
                         $time, hi_o, lo_o, busy, done, req_ready, m_hi, m_lo, (m_left != 0), m_done,
                         ((m_left == 0) && !rst));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors = vectors + 1;
        if (act !== exp) begin
            miscompares = miscompares + 1;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic req(input logic [2:0] op, input logic [31:0] h, input logic [31:0] l,
                       input logic [31:0] a, input logic [31:0] b);
        req_valid = 1'b1; req_op = op; hi_in = h; lo_in = l; src_a = a; src_b = b;
    endtask

    task automatic idle();
        req_valid = 1'b0; req_op = 3'd0;
    endtask

    initial begin
        vectors = 0; miscompares = 0; check_en = 0;
        rst = 1'b1; req_valid = 0; req_op = 0; hi_in = 0; lo_in = 0; src_a = 0; src_b = 0;
        cyc();
        check_en = 1;
        cyc();
        chk("reset_hi", hi_o, 32'h0);
        chk("reset_lo", lo_o, 32'h0);
        chk("reset_busy", {31'h0, busy}, 32'h0);
        chk("reset_done", {31'h0, done}, 32'h0);
        chk("reset_ready", {31'h0, req_ready}, 32'h0);
        rst = 1'b0;

        // WBOTH then hold
        req(3'd3, 32'h1, 32'h2, 0, 0); cyc(); idle();
        chk("wboth_hi", hi_o, 32'h1);
        chk("wboth_lo", lo_o, 32'h2);
        cyc(); cyc(); cyc();
        chk("hold_hi", hi_o, 32'h1);
        chk("hold_lo", lo_o, 32'h2);

        // MADD signed -1*3 onto 5
        req(3'd3, 32'h0, 32'h5, 0, 0); cyc();
        req(3'd4, 0, 0, 32'hFFFF_FFFF, 32'h3); cyc(); idle();
        chk("madd_c1_busy", {31'h0, busy}, 32'h1);
        chk("madd_c1_ready", {31'h0, req_ready}, 32'h0);
        cyc();
        chk("madd_c2_busy", {31'h0, busy}, 32'h1);
        chk("madd_c2_done", {31'h0, done}, 32'h0);
        cyc();
        chk("madd_hi", hi_o, 32'h0);
        chk("madd_lo", lo_o, 32'h2);
        chk("madd_done", {31'h0, done}, 32'h1);
        chk("madd_ready", {31'h0, req_ready}, 32'h1);
        cyc();
        chk("madd_done_pulse", {31'h0, done}, 32'h0);

        // MADDU max*max
        req(3'd3, 0, 0, 0, 0); cyc();
        req(3'd5, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF); cyc(); idle(); cyc(); cyc();
        chk("maddu_hi", hi_o, 32'hFFFF_FFFE);
        chk("maddu_lo", lo_o, 32'h0000_0001);

        // MSUB below zero, then MADDU wraps back, issued in the done cycle
        req(3'd3, 0, 0, 0, 0); cyc();
        req(3'd6, 0, 0, 32'h1, 32'h1); cyc(); idle(); cyc(); cyc();
        chk("msub_hi", hi_o, 32'hFFFF_FFFF);
        chk("msub_lo", lo_o, 32'hFFFF_FFFF);
        req(3'd5, 0, 0, 32'h1, 32'h1); cyc(); idle(); cyc(); cyc();
        chk("wrap_hi", hi_o, 32'h0);
        chk("wrap_lo", lo_o, 32'h0);

        // WHI held during MADD lands after the result
        req(3'd3, 0, 0, 0, 0); cyc();
        req(3'd4, 0, 0, 32'h2, 32'h3); cyc();
        req(3'd1, 32'hAA, 0, 0, 0); cyc();
        chk("hold_c2_hi", hi_o, 32'h0);
        cyc();
        chk("hold_c3_hi", hi_o, 32'h0);
        chk("hold_c3_lo", lo_o, 32'h6);
        cyc(); idle();
        chk("hold_c4_hi", hi_o, 32'hAA);
        chk("hold_c4_lo", lo_o, 32'h6);

        // Reset during MUL aborts
        req(3'd3, 32'h7, 32'h7, 0, 0); cyc();
        req(3'd4, 0, 0, 32'h1, 32'h1); cyc(); idle();
        rst = 1'b1; cyc();
        chk("abort_hi", hi_o, 32'h0);
        chk("abort_lo", lo_o, 32'h0);
        chk("abort_busy", {31'h0, busy}, 32'h0);
        rst = 1'b0; #1;
        chk("abort_ready", {31'h0, req_ready}, 32'h1);
        cyc();
        chk("abort_no_done", {31'h0, done}, 32'h0);
        cyc();
        chk("abort_no_done2", {31'h0, done}, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            req_valid = ($urandom_range(0, 3) != 0);
            req_op    = 3'($urandom_range(0, 7));
            hi_in     = $urandom;
            lo_in     = $urandom;
            src_a     = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFFF : $urandom;
            src_b     = ($urandom_range(0, 4) == 0) ? 32'h8000_0000 : $urandom;
            rst       = ($urandom_range(0, 60) == 0);
            cyc();
        end
        rst = 1'b0; idle();
        cyc(); cyc(); cyc();

        check_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
